uart_tx_corr2: RTL and testbench
================================

// Module: uart_tx_corr2
//
// PURPOSE
// - UART transmitter. Serializes one AXI-Stream byte per frame onto txd.
// - Frame: start(0), DATA_WIDTH data bits, stop(1); bit order selectable.
// - Sits between an AXI-Stream byte source and the chip's serial TX pin.
// - Corrected variant: default order is LSB-first (d0 first after start).
//
// PARAMETERS
// - DATA_WIDTH  8  payload bits per frame
// - BIG_ENDIAN  0  0 = LSB-first; 1 = MSB-first
//
// PORTS
// - clk            in   1           system clock, all logic on rising edge
// - rst            in   1           reset, asynchronous, active-high
// - s_axis_tdata   in   DATA_WIDTH  byte to send
// - s_axis_tvalid  in   1           source has data
// - s_axis_tready  out  1           transmitter can accept a word
// - txd            out  1           serial output, idle high
// - busy           out  1           frame in progress
// - prescale       in   16          bit time = prescale*8 clk cycles
//
// BEHAVIOUR
// - Reset (async assert): txd=1, busy=0, s_axis_tready=0, counters/shift reg cleared.
// - First clk edge after rst deasserts: s_axis_tready=1 (idle).
// - Accept on rising edge with s_axis_tvalid && s_axis_tready.
//   - Latch tdata, bit-reversed if BIG_ENDIAN=1.
//   - Latch prescale; a latched value of 0 is treated as 1.
//   - Next cycle: s_axis_tready=0, busy=1, txd=0 (start bit).
// - All outputs are registered. No combinational path from inputs to outputs.
// - States and dwell times (BT = latched prescale*8 cycles):
//   - IDLE: txd=1.
//   - START: BT cycles.
//   - DATA: DATA_WIDTH bits, BT cycles each; txd = shift_reg[0], shift right per bit.
//   - STOP: txd=1 for BT cycles.
//   - Then back to IDLE: busy=0, s_axis_tready=1.
// - Bit-time counter: 19 bits wide, no overflow at prescale=16'hFFFF.
// - Bit order examples (tdata=0x2D):
//   - BIG_ENDIAN=0 sends 1,0,1,1,0,1,0,0.
//   - BIG_ENDIAN=1 sends 0,0,1,0,1,1,0,1.
// - Inputs are ignored while busy. tvalid held through a frame is accepted in the
//   first IDLE cycle after STOP. Minimum gap between frames = 1 idle cycle at txd=1.
// - prescale changes mid-frame have no effect until the next accept.
// - rst asserted mid-frame aborts the frame immediately: txd=1, no partial stop bit.
//
// CONFIGURATION
// - UART_TX_PARITY_EN defined: one even-parity bit (XOR of data bits), BT cycles,
//   between the last data bit and STOP. Frame = DATA_WIDTH+3 bits.
// - UART_TX_PARITY_EN undefined: no parity state. Frame = DATA_WIDTH+2 bits.
//
// TESTING
// - prescale=6, BIG_ENDIAN=0, send 0x2D.
//   -> start edge, then sample at 1.5*BT and every BT after; LSB-first rebuild = 0x2D.
// - BIG_ENDIAN=1, send 0x2D -> LSB-first rebuild = 0xB4.
// - prescale=1, send 0x00 -> txd low exactly 72 cycles (start + 8 data),
//   then high 8 cycles; busy high 80 cycles.
// - tvalid held high with 0x55 then 0xA3 -> two frames; tready high exactly 1 cycle
//   between frames; both bytes decode correctly.
// - rst pulse mid data bit 3 -> txd=1, busy=0 asynchronously; the next frame
//   after release is correct.
// - UART_TX_PARITY_EN defined, send 0x07 -> parity bit=1, then stop=1.

Source files
------------

// File: rtl/uart_tx_corr2.sv
// uart_tx_corr2: AXI-Stream to UART transmitter.
// Frame: start(0), DATA_WIDTH data bits, optional even parity, stop(1).
// Bit time = latched prescale * 8 clk cycles (prescale 0 behaves as 1).
// Optional feature: define UART_TX_PARITY_EN to insert one even-parity bit
// between the last data bit and the stop bit.
// Handshake: a word is taken on a rising edge where s_axis_tvalid and
// s_axis_tready are both high; tvalid may be held, tready is registered and
// only high while idle, so the source never sees a combinational path.
module uart_tx_corr2 #(
    parameter int DATA_WIDTH = 8,
    parameter int BIG_ENDIAN = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  txd,
    output logic                  busy,
    input  logic [15:0]           prescale
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] data_in;
    logic [18:0]           bt_len;
    logic [18:0]           bt_cnt;
    logic [18:0]           bt_new;
    logic [15:0]           ps_eff;
    logic [IDX_W-1:0]      bit_idx;
    logic                  bt_done;
`ifdef UART_TX_PARITY_EN
    logic                  parity_bit;
`endif

    // Word as it will be shifted out LSB-first; MSB-first order is a reversal
    always_comb begin
        data_in = s_axis_tdata;
        if (BIG_ENDIAN != 0) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                data_in[i] = s_axis_tdata[DATA_WIDTH-1-i];
            end
        end
    end

    // Bit time from the live prescale input; 19 bits hold 16'hFFFF * 8
    always_comb begin
        ps_eff  = (prescale == 16'd0) ? 16'd1 : prescale;
        bt_new  = {ps_eff, 3'b000};
        bt_done = (bt_cnt == (bt_len - 19'd1));
    end

    // Transmit FSM with registered txd, busy and s_axis_tready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            shift_reg     <= '0;
            bt_len        <= 19'd8;
            bt_cnt        <= '0;
            bit_idx       <= '0;
            txd           <= 1'b1;
            busy          <= 1'b0;
            s_axis_tready <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    txd           <= 1'b1;
                    busy          <= 1'b0;
                    s_axis_tready <= 1'b1;
                    if (s_axis_tready && s_axis_tvalid) begin
                        state         <= S_START;
                        shift_reg     <= data_in;
                        bt_len        <= bt_new;
                        bt_cnt        <= '0;
                        bit_idx       <= '0;
                        txd           <= 1'b0;
                        busy          <= 1'b1;
                        s_axis_tready <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_bit    <= ^s_axis_tdata;
`endif
                    end
                end
                S_START: begin
                    if (bt_done) begin
                        state     <= S_DATA;
                        bt_cnt    <= '0;
                        txd       <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end else begin
                        bt_cnt <= bt_cnt + 19'd1;
                    end
                end
                S_DATA: begin
                    if (bt_done) begin
                        bt_cnt <= '0;
                        if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
                            txd   <= parity_bit;
`else
                            state <= S_STOP;
                            txd   <= 1'b1;
`endif
                        end else begin
                            bit_idx   <= bit_idx + IDX_W'(1);
                            txd       <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        bt_cnt <= bt_cnt + 19'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bt_done) begin
                        state  <= S_STOP;
                        bt_cnt <= '0;
                        txd    <= 1'b1;
                    end else begin
                        bt_cnt <= bt_cnt + 19'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (bt_done) begin
                        state         <= S_IDLE;
                        bt_cnt        <= '0;
                        busy          <= 1'b0;
                        s_axis_tready <= 1'b1;
                    end else begin
                        bt_cnt <= bt_cnt + 19'd1;
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    txd           <= 1'b1;
                    busy          <= 1'b0;
                    s_axis_tready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_corr2.sv
// tb_uart_tx_corr2: random and directed frames on an LSB-first and an
// MSB-first instance, compared cycle by cycle against an ideal frame model.
module tb_uart_tx_corr2;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] tdata = '0;
    logic          tvalid = 1'b0;
    logic [15:0]   prescale = 16'd1;
    logic          tready_le, txd_le, busy_le;
    logic          tready_be, txd_be, busy_be;

    int n_checks = 0;
    int n_errors = 0;

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    uart_tx_corr2 #(.DATA_WIDTH(DW), .BIG_ENDIAN(0)) dut_le (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tready(tready_le), .txd(txd_le), .busy(busy_le), .prescale(prescale)
    );

    uart_tx_corr2 #(.DATA_WIDTH(DW), .BIG_ENDIAN(1)) dut_be (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tready(tready_be), .txd(txd_be), .busy(busy_be), .prescale(prescale)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] reverse(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = d[DW-1-i];
        return r;
    endfunction

    // Ideal line level of frame bit idx: start, data, [parity], stop
    function automatic logic frame_bit(input logic [DW-1:0] d, input bit msb_first, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DW) return msb_first ? d[DW-idx] : d[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == DW + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    // Present a word and wait for the accepting edge
    task automatic accept_word(input logic [DW-1:0] d, input logic [15:0] ps);
        int waited;
        @(negedge clk);
        tdata    = d;
        prescale = ps;
        tvalid   = 1'b1;
        waited   = 0;
        while (!(tready_le && tready_be) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("accept_wait", (waited < 100) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk);
    endtask

    // Follow one frame from the cycle after accept through the idle cycle
    task automatic check_frame(input logic [DW-1:0] d, input logic [15:0] ps,
                               input bit hold, input logic [DW-1:0] next_d,
                               input bit scramble_ps,
                               output logic [DW-1:0] rb_le, output logic [DW-1:0] rb_be);
        int bt;
        int bad_le;
        int bad_be;
        int b;
        bt     = ((ps == 16'd0) ? 1 : int'(ps)) * 8;
        bad_le = 0;
        bad_be = 0;
        rb_le  = '0;
        rb_be  = '0;
        for (int i = 0; i < NB * bt; i++) begin
            @(negedge clk);
            if (i == 0) begin
                if (hold) tdata = next_d;
                else tvalid = 1'b0;
            end
            if (scramble_ps && i == 3) prescale = 16'($urandom_range(1, 9));
            b = i / bt;
            if (txd_le !== frame_bit(d, 1'b0, b) || busy_le !== 1'b1 || tready_le !== 1'b0) bad_le++;
            if (txd_be !== frame_bit(d, 1'b1, b) || busy_be !== 1'b1 || tready_be !== 1'b0) bad_be++;
            if ((i % bt) == bt / 2 && b >= 1 && b <= DW) begin
                rb_le[b-1] = txd_le;
                rb_be[b-1] = txd_be;
            end
        end
        check("wave_le", bad_le, 0);
        check("wave_be", bad_be, 0);
        @(negedge clk);
        check("end_busy_le", busy_le, 0);
        check("end_rdy_le", tready_le, 1);
        check("end_txd_le", txd_le, 1);
        check("end_busy_be", busy_be, 0);
        check("end_rdy_be", tready_be, 1);
        check("end_txd_be", txd_be, 1);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [15:0]   ps;
        logic [DW-1:0] rl;
        logic [DW-1:0] rb;

        // reset state
        #12;
        check("rst_txd", {txd_le, txd_be}, 2'b11);
        check("rst_busy", {busy_le, busy_be}, 2'b00);
        check("rst_rdy", {tready_le, tready_be}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_rdy", {tready_le, tready_be}, 2'b11);
        check("idle_txd", {txd_le, txd_be}, 2'b11);

        // prescale 6, 0x2D: both orders, rebuilt LSB-first
        accept_word(8'h2D, 16'd6);
        check_frame(8'h2D, 16'd6, 1'b0, 8'h00, 1'b0, rl, rb);
        check("rb_2d_le", rl, 8'h2D);
        check("rb_2d_be", rb, 8'hB4);

        // prescale 1, 0x00: txd low for start + data, busy for the whole frame
        accept_word(8'h00, 16'd1);
        check_frame(8'h00, 16'd1, 1'b0, 8'h00, 1'b0, rl, rb);
        check("rb_00_le", rl, 8'h00);

        // prescale 0 behaves as 1
        accept_word(8'hC6, 16'd0);
        check_frame(8'hC6, 16'd0, 1'b0, 8'h00, 1'b0, rl, rb);
        check("rb_ps0_le", rl, 8'hC6);

        // tvalid held: 0x55 then 0xA3 back to back, one ready cycle between
        accept_word(8'h55, 16'd2);
        check_frame(8'h55, 16'd2, 1'b1, 8'hA3, 1'b0, rl, rb);
        check("rb_55_le", rl, 8'h55);
        check("rb_55_be", rb, reverse(8'h55));
        check_frame(8'hA3, 16'd2, 1'b0, 8'h00, 1'b0, rl, rb);
        check("rb_a3_le", rl, 8'hA3);
        check("rb_a3_be", rb, reverse(8'hA3));

        // reset in the middle of data bit 3
        accept_word(8'h9E, 16'd1);
        @(negedge clk);
        tvalid = 1'b0;
        for (int i = 1; i < 4 * 8 + 4; i++) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_txd", {txd_le, txd_be}, 2'b11);
        check("abort_busy", {busy_le, busy_be}, 2'b00);
        check("abort_rdy", {tready_le, tready_be}, 2'b00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        accept_word(8'h3C, 16'd1);
        check_frame(8'h3C, 16'd1, 1'b0, 8'h00, 1'b0, rl, rb);
        check("rb_post_rst_le", rl, 8'h3C);
        check("rb_post_rst_be", rb, reverse(8'h3C));

`ifdef UART_TX_PARITY_EN
        // 0x07 has odd weight, so the parity bit is 1
        accept_word(8'h07, 16'd1);
        check_frame(8'h07, 16'd1, 1'b0, 8'h00, 1'b0, rl, rb);
        check("rb_07_le", rl, 8'h07);
`endif

        // random frames, prescale disturbed mid-frame
        for (int n = 0; n < 16; n++) begin
            d  = DW'($urandom);
            ps = 16'($urandom_range(0, 4));
            accept_word(d, ps);
            check_frame(d, ps, 1'b0, 8'h00, 1'b1, rl, rb);
            check("rb_rand_le", rl, d);
            check("rb_rand_be", rb, reverse(d));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
